computer_move_generator: RTL

- Automatic opponent for the tic-tac-toe game. It drives the computer side of the move interface: it reads the nine board cells, picks a legal move and presents `computer_position` with a one-cycle `pc` strobe.
- Sits beside the game top. Its `computer_position`/`pc` outputs feed the game's same-named inputs; the game's `pos1..pos9` outputs feed this block.
- Cell encoding: 2'b00 empty, 2'b01 player, 2'b10 computer. Position index 0..8 maps to pos1..pos9.

---
 rtl/computer_move_generator_pkg.sv | 38 +++
 rtl/computer_move_generator_line_eval.sv | 34 +++
 rtl/computer_move_generator.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/computer_move_generator_pkg.sv
// Shared definitions for the tic-tac-toe computer opponent: cell encoding,
// controller states, the eight winning lines and the corner/edge search order.
package ttt_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_PICK,
    ST_ISSUE
  } cmg_state_t;

  localparam logic [3:0] LINE_TABLE [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] CENTER_IDX = 4'd4;
  localparam logic [3:0] CORNER_ORDER [0:3] = '{4'd0, 4'd2, 4'd6, 4'd8};
  localparam logic [3:0] EDGE_ORDER   [0:3] = '{4'd1, 4'd3, 4'd5, 4'd7};

  // Board is packed two bits per cell, cell 0 in bits [1:0].
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] idx);
    logic [17:0] sh;
    sh = board >> {idx, 1'b0};
    return sh[1:0];
  endfunction

endpackage

// File: rtl/computer_move_generator_line_eval.sv
// Combinational evaluation of one board line: flags a two-in-a-line with one
// gap for either side and reports the index of the empty cell.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [3:0] idx_a,
  input  logic [3:0] idx_b,
  input  logic [3:0] idx_c,
  output logic       win_hit,
  output logic       block_hit,
  output logic [3:0] empty_idx
);

  logic [1:0] n_empty;
  logic [1:0] n_comp;
  logic [1:0] n_play;

  always_comb begin
    n_empty = 2'(cell_a == CELL_EMPTY) + 2'(cell_b == CELL_EMPTY) + 2'(cell_c == CELL_EMPTY);
    n_comp  = 2'(cell_a == CELL_COMPUTER) + 2'(cell_b == CELL_COMPUTER) + 2'(cell_c == CELL_COMPUTER);
    n_play  = 2'(cell_a == CELL_PLAYER) + 2'(cell_b == CELL_PLAYER) + 2'(cell_c == CELL_PLAYER);

    win_hit   = (n_comp == 2'd2) && (n_empty == 2'd1);
    block_hit = (n_play == 2'd2) && (n_empty == 2'd1);

    if (cell_a == CELL_EMPTY)      empty_idx = idx_a;
    else if (cell_b == CELL_EMPTY) empty_idx = idx_b;
    else                           empty_idx = idx_c;
  end

endmodule

// File: rtl/computer_move_generator.sv
// Computer opponent: snapshots the board, scans the eight lines one per cycle,
// then picks win > block > centre/corners > edges. CMG_EASY_EN drops blocking.
module computer_move_generator
  import ttt_pkg::*;
#(
  parameter int POS_W        = 4,
  parameter bit CENTER_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             game_over,
  input  logic [1:0]       pos1,
  input  logic [1:0]       pos2,
  input  logic [1:0]       pos3,
  input  logic [1:0]       pos4,
  input  logic [1:0]       pos5,
  input  logic [1:0]       pos6,
  input  logic [1:0]       pos7,
  input  logic [1:0]       pos8,
  input  logic [1:0]       pos9,
  output logic [POS_W-1:0] computer_position,
  output logic             pc,
  output logic             no_move,
  output logic             busy
);

  cmg_state_t  state;
  logic [17:0] snap;
  logic [2:0]  line_idx;
  logic        win_valid;
  logic [3:0]  win_idx;
  logic        blk_valid;
  logic [3:0]  blk_idx;

  logic [3:0]  la, lb, lc;
  logic        win_hit;
  logic        block_hit;
  logic [3:0]  empty_idx;

  logic [3:0]  pick_idx;
  logic        any_empty;
  logic        found;

  assign la = LINE_TABLE[line_idx][0];
  assign lb = LINE_TABLE[line_idx][1];
  assign lc = LINE_TABLE[line_idx][2];

  ttt_line_eval u_line_eval (
    .cell_a    (cell_at(snap, la)),
    .cell_b    (cell_at(snap, lb)),
    .cell_c    (cell_at(snap, lc)),
    .idx_a     (la),
    .idx_b     (lb),
    .idx_c     (lc),
    .win_hit   (win_hit),
`ifdef CMG_EASY_EN
    .block_hit (),
`else
    .block_hit (block_hit),
`endif
    .empty_idx (empty_idx)
  );

`ifdef CMG_EASY_EN
  assign block_hit = 1'b0;
`endif

  // Move choice from the snapshot and the candidates gathered during SCAN.
  always_comb begin
    pick_idx  = '0;
    any_empty = 1'b0;
    found     = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (cell_at(snap, 4'(i)) == CELL_EMPTY) any_empty = 1'b1;
    end
    if (win_valid) begin
      pick_idx = win_idx;
      found    = 1'b1;
    end else if (blk_valid) begin
      pick_idx = blk_idx;
      found    = 1'b1;
    end
    if (!found && CENTER_FIRST && cell_at(snap, CENTER_IDX) == CELL_EMPTY) begin
      pick_idx = CENTER_IDX;
      found    = 1'b1;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && cell_at(snap, CORNER_ORDER[k]) == CELL_EMPTY) begin
        pick_idx = CORNER_ORDER[k];
        found    = 1'b1;
      end
    end
    if (!found && !CENTER_FIRST && cell_at(snap, CENTER_IDX) == CELL_EMPTY) begin
      pick_idx = CENTER_IDX;
      found    = 1'b1;
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && cell_at(snap, EDGE_ORDER[k]) == CELL_EMPTY) begin
        pick_idx = EDGE_ORDER[k];
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      snap              <= '0;
      line_idx          <= '0;
      win_valid         <= 1'b0;
      win_idx           <= '0;
      blk_valid         <= 1'b0;
      blk_idx           <= '0;
      computer_position <= '0;
      pc                <= 1'b0;
      no_move           <= 1'b0;
      busy              <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req && !game_over) begin
            snap      <= {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
            line_idx  <= '0;
            win_valid <= 1'b0;
            win_idx   <= '0;
            blk_valid <= 1'b0;
            blk_idx   <= '0;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Only the lowest-numbered line of each kind is kept.
          if (win_hit && !win_valid) begin
            win_valid <= 1'b1;
            win_idx   <= empty_idx;
          end
          if (block_hit && !blk_valid) begin
            blk_valid <= 1'b1;
            blk_idx   <= empty_idx;
          end
          line_idx <= line_idx + 3'd1;
          if (line_idx == 3'd7) state <= ST_PICK;
        end
        ST_PICK: begin
          if (any_empty) begin
            computer_position <= POS_W'(pick_idx);
            pc                <= 1'b1;
          end else begin
            no_move <= 1'b1;
          end
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          pc      <= 1'b0;
          no_move <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
